// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared states and constants for the 2x2 systolic array sequencer
package sa_pkg;

    localparam int DW_DEF         = 8;
    localparam int CW_DEF         = 16;
    localparam int COMPUTE_CYCLES = 5;
    localparam int LOAD_BYTES     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        COMPUTE,
        DRAIN
    } sa_state_e;

endpackage

// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - skewed row/column operand mux for a 2x2 output-stationary array
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          en,
    input  logic [2:0]    t,
    input  logic [DW-1:0] a00,
    input  logic [DW-1:0] a01,
    input  logic [DW-1:0] a10,
    input  logic [DW-1:0] a11,
    input  logic [DW-1:0] b00,
    input  logic [DW-1:0] b01,
    input  logic [DW-1:0] b10,
    input  logic [DW-1:0] b11,
    output logic [DW-1:0] a0,
    output logic [DW-1:0] a1,
    output logic [DW-1:0] b0,
    output logic [DW-1:0] b1
);

    // Row 1 and column 1 lag by one cycle so operands meet inside the array.
    always_comb begin
        a0 = '0;
        a1 = '0;
        b0 = '0;
        b1 = '0;
        if (en) begin
            case (t)
                3'd0: begin
                    a0 = a00;
                    b0 = b00;
                end
                3'd1: begin
                    a0 = a01;
                    a1 = a10;
                    b0 = b10;
                    b1 = b01;
                end
                3'd2: begin
                    a1 = a11;
                    b1 = b11;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sa_sequencer.sv
// rtl/sa_sequencer.sv - load/clear/compute/drain sequencer for a 2x2 systolic array
// Optional SA_SEQ_SAT_EN: saturate each result to signed 8 bits and drain 4 bytes.
module sa_sequencer
    import sa_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          cmd_valid,
    input  logic [DW-1:0] cmd_data,
    output logic          cmd_ready,
    output logic          sa_clr,
    output logic          sa_en,
    output logic [DW-1:0] sa_a0,
    output logic [DW-1:0] sa_a1,
    output logic [DW-1:0] sa_b0,
    output logic [DW-1:0] sa_b1,
    input  logic [CW-1:0] sa_c00,
    input  logic [CW-1:0] sa_c01,
    input  logic [CW-1:0] sa_c10,
    input  logic [CW-1:0] sa_c11,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready
);

`ifdef SA_SEQ_SAT_EN
    localparam int DRAIN_BYTES = 4;

    function automatic logic [7:0] drain_byte(input logic [CW-1:0] r0, input logic [CW-1:0] r1,
                                              input logic [CW-1:0] r2, input logic [CW-1:0] r3,
                                              input logic [2:0] idx);
        logic [CW-1:0] r;
        case (idx)
            3'd0:    r = r0;
            3'd1:    r = r1;
            3'd2:    r = r2;
            default: r = r3;
        endcase
        if ($signed(r) > 127)       return 8'h7F;
        else if ($signed(r) < -128) return 8'h80;
        else                        return r[7:0];
    endfunction
`else
    localparam int DRAIN_BYTES = 8;

    // Byte idx walks c00..c11, low byte of each result first.
    function automatic logic [7:0] drain_byte(input logic [CW-1:0] r0, input logic [CW-1:0] r1,
                                              input logic [CW-1:0] r2, input logic [CW-1:0] r3,
                                              input logic [2:0] idx);
        logic [CW-1:0] r;
        case (idx[2:1])
            2'd0:    r = r0;
            2'd1:    r = r1;
            2'd2:    r = r2;
            default: r = r3;
        endcase
        return idx[0] ? r[15:8] : r[7:0];
    endfunction
`endif

    localparam logic [2:0] B_LAST = 3'(LOAD_BYTES - 1);
    localparam logic [2:0] T_LAST = 3'(COMPUTE_CYCLES - 1);
    localparam logic [2:0] D_LAST = 3'(DRAIN_BYTES - 1);

    sa_state_e     state;
    logic [2:0]    byte_cnt;
    logic [2:0]    t_cnt;
    logic [2:0]    drain_idx;
    logic [DW-1:0] ops [LOAD_BYTES];
    logic [CW-1:0] res [4];

    logic          feed_en;
    logic [2:0]    feed_t;
    logic [DW-1:0] feed_a0, feed_a1, feed_b0, feed_b1;

    // Feeder looks one cycle ahead so the array drive can stay registered.
    assign feed_en = (state == CLEAR) || ((state == COMPUTE) && (t_cnt != T_LAST));
    assign feed_t  = (state == CLEAR) ? 3'd0 : t_cnt + 3'd1;

    sa_skew_feeder #(.DW(DW)) u_feeder (
        .en  (feed_en),
        .t   (feed_t),
        .a00 (ops[0]),
        .a01 (ops[1]),
        .a10 (ops[2]),
        .a11 (ops[3]),
        .b00 (ops[4]),
        .b01 (ops[5]),
        .b10 (ops[6]),
        .b11 (ops[7]),
        .a0  (feed_a0),
        .a1  (feed_a1),
        .b0  (feed_b0),
        .b1  (feed_b1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            t_cnt     <= '0;
            drain_idx <= '0;
            for (int i = 0; i < LOAD_BYTES; i++) ops[i] <= '0;
            for (int i = 0; i < 4; i++) res[i] <= '0;
            cmd_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sa_en     <= 1'b0;
            sa_clr    <= 1'b0;
            sa_a0     <= '0;
            sa_a1     <= '0;
            sa_b0     <= '0;
            sa_b1     <= '0;
        end else if (!ena) begin
            // Abandon any partial load or undrained result.
            state     <= IDLE;
            byte_cnt  <= '0;
            t_cnt     <= '0;
            drain_idx <= '0;
            for (int i = 0; i < 4; i++) res[i] <= '0;
            cmd_ready <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sa_en     <= 1'b0;
            sa_clr    <= 1'b0;
            sa_a0     <= '0;
            sa_a1     <= '0;
            sa_b0     <= '0;
            sa_b1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        ops[0]   <= cmd_data;
                        byte_cnt <= 3'd1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (cmd_valid && cmd_ready) begin
                        ops[byte_cnt] <= cmd_data;
                        byte_cnt      <= byte_cnt + 3'd1;
                        if (byte_cnt == B_LAST) begin
                            cmd_ready <= 1'b0;
                            sa_clr    <= 1'b1;
                            state     <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    sa_clr <= 1'b0;
                    sa_en  <= 1'b1;
                    t_cnt  <= '0;
                    sa_a0  <= feed_a0;
                    sa_a1  <= feed_a1;
                    sa_b0  <= feed_b0;
                    sa_b1  <= feed_b1;
                    state  <= COMPUTE;
                end
                COMPUTE: begin
                    sa_a0 <= feed_a0;
                    sa_a1 <= feed_a1;
                    sa_b0 <= feed_b0;
                    sa_b1 <= feed_b1;
                    if (t_cnt == T_LAST) begin
                        sa_en     <= 1'b0;
                        res[0]    <= sa_c00;
                        res[1]    <= sa_c01;
                        res[2]    <= sa_c10;
                        res[3]    <= sa_c11;
                        out_valid <= 1'b1;
                        out_data  <= drain_byte(sa_c00, sa_c01, sa_c10, sa_c11, 3'd0);
                        drain_idx <= '0;
                        state     <= DRAIN;
                    end else begin
                        t_cnt <= t_cnt + 3'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (drain_idx == D_LAST) begin
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            drain_idx <= '0;
                            cmd_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            drain_idx <= drain_idx + 3'd1;
                            out_data  <= drain_byte(res[0], res[1], res[2], res[3], drain_idx + 3'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_sequencer.sv
// tb/tb_sa_sequencer.sv - randomized self-checking bench with a behavioural 2x2 array and matmul model
module tb_sa_sequencer;

`ifdef SA_SEQ_SAT_EN
    localparam int NB = 4;
`else
    localparam int NB = 8;
`endif

    logic              clk = 1'b0;
    logic              rst_n, ena, cmd_valid, cmd_ready;
    logic [7:0]        cmd_data;
    logic              sa_clr, sa_en;
    logic signed [7:0] sa_a0, sa_a1, sa_b0, sa_b1;
    logic              out_valid, out_ready;
    logic [7:0]        out_data;

    logic signed [15:0] acc00 = 0, acc01 = 0, acc10 = 0, acc11 = 0;
    logic signed [7:0]  ap0 = 0, ap1 = 0, bp0 = 0, bp1 = 0;

    int checks = 0;
    int errors = 0;
    int clr_total = 0;
    int en_total = 0;

    always #5 clk = ~clk;

    sa_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .sa_clr    (sa_clr),
        .sa_en     (sa_en),
        .sa_a0     (sa_a0),
        .sa_a1     (sa_a1),
        .sa_b0     (sa_b0),
        .sa_b1     (sa_b1),
        .sa_c00    (acc00),
        .sa_c01    (acc01),
        .sa_c10    (acc10),
        .sa_c11    (acc11),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    // Output-stationary PEs; a flows right, b flows down, one cycle per hop.
    always @(posedge clk) begin
        if (sa_clr) begin
            acc00 <= 0; acc01 <= 0; acc10 <= 0; acc11 <= 0;
            ap0 <= 0; ap1 <= 0; bp0 <= 0; bp1 <= 0;
        end else if (sa_en) begin
            acc00 <= acc00 + sa_a0 * sa_b0;
            acc01 <= acc01 + ap0 * sa_b1;
            acc10 <= acc10 + sa_a1 * bp0;
            acc11 <= acc11 + ap1 * bp1;
            ap0 <= sa_a0; ap1 <= sa_a1; bp0 <= sa_b0; bp1 <= sa_b1;
        end
    end

    always @(negedge clk) begin
        if (sa_clr) clr_total++;
        if (sa_en) en_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte i of v: 0..3 = A00,A01,A10,A11; 4..7 = B00,B01,B10,B11.
    function automatic logic [63:0] model(input logic [63:0] v);
        int a [4];
        int b [4];
        int c, i, j;
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            a[k] = int'($signed(v[8*k +: 8]));
            b[k] = int'($signed(v[32 + 8*k +: 8]));
        end
        for (int m = 0; m < 4; m++) begin
            i = m / 2;
            j = m % 2;
            c = a[2*i] * b[j] + a[2*i+1] * b[2+j];
            c = int'($signed(16'(c)));
`ifdef SA_SEQ_SAT_EN
            if (c > 127) c = 127;
            else if (c < -128) c = -128;
            r[8*m +: 8] = 8'(c);
`else
            r[16*m +: 16] = 16'(c);
`endif
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_in_time", 32'(n < 50), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    // mode 0: random out_ready, 1: three stall cycles per byte, 2: always ready
    task automatic receive(input string tag, input logic [63:0] exp, input int mode);
        int got, cyc, st;
        logic stalled;
        logic [7:0] prev;
        got = 0; cyc = 0; st = 0; stalled = 1'b0; prev = '0;
        while (got < NB && cyc < 300) begin
            if (stalled) check($sformatf("%s_hold%0d", tag, got), out_data, prev);
            if (mode == 1)      out_ready = out_valid && (st >= 3);
            else if (mode == 0) out_ready = ($urandom_range(0, 2) != 0);
            else                out_ready = 1'b1;
            if (out_valid && out_ready) begin
                check($sformatf("%s_byte%0d", tag, got), out_data, exp[8*got +: 8]);
                got++;
                st = 0;
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                prev = out_data;
                st++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check({tag, "_count"}, got, NB);
        check({tag, "_ready_after"}, cmd_ready, 1);
        check({tag, "_valid_after"}, out_valid, 0);
    endtask

    task automatic run_txn(input string tag, input logic [63:0] v, input int mode);
        int clr0, en0;
        clr0 = clr_total;
        en0  = en_total;
        for (int i = 0; i < 8; i++) send_byte(v[8*i +: 8]);
        receive(tag, model(v), mode);
        check({tag, "_clr_cycles"}, clr_total - clr0, 1);
        check({tag, "_en_cycles"}, en_total - en0, 5);
    endtask

    initial begin
        int n, clr0;
        logic [63:0] v;
        rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0; cmd_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sa_en", sa_en, 0);
        check("rst_sa_clr", sa_clr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        run_txn("seq", 64'h0807060504030201, 2);
        run_txn("diag", 64'h64000064FF0000FF, 2);
        run_txn("stall", {$urandom, $urandom}, 1);

        // Reset at COMPUTE t2 must silence every output immediately.
        v = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) send_byte(v[8*i +: 8]);
        n = 0;
        while (!sa_clr && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_saw_clear", sa_clr, 1);
        repeat (3) @(negedge clk);
        check("abort_t2_en", sa_en, 1);
        rst_n = 1'b0;
        #1;
        check("abort_sa_en", sa_en, 0);
        check("abort_sa_clr", sa_clr, 0);
        check("abort_operands", {sa_a0, sa_a1, sa_b0, sa_b1}, 0);
        check("abort_cmd_ready", cmd_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_cmd_ready_back", cmd_ready, 1);
        run_txn("after_abort", {$urandom, $urandom}, 0);

        // Dropping ena mid-load discards the partial operands.
        v = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) send_byte(v[8*i +: 8]);
        clr0 = clr_total;
        ena = 1'b0;
        @(negedge clk);
        check("ena_cmd_ready", cmd_ready, 0);
        check("ena_sa_clr", sa_clr, 0);
        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        check("ena_no_clear", clr_total - clr0, 0);
        run_txn("ena_reload", {$urandom, $urandom}, 0);

`ifdef SA_SEQ_SAT_EN
        run_txn("sat_pos", 64'h7F7F7F7F7F7F7F7F, 2);
        run_txn("sat_neg", 64'h7F7F7F7F80808080, 0);
`endif

        for (int k = 0; k < 6; k++) run_txn($sformatf("rand%0d", k), {$urandom, $urandom}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
